mult_job_sequencer: RTL and testbench

MULT_JOB_SEQUENCER -- requirements
Module: mult_job_sequencer

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_op_fifo.sv | 63 ++++++
 rtl/mult_job_sequencer.sv | 138 +++++++++++++
 tb/tb_mult_job_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier job sequencer and its operand queue.
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair queue: power-of-two depth, pointers wrap naturally, level counts 0..DEPTH.
module mult_op_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/mult_job_sequencer.sv
// Queues operand pairs and runs them one at a time through an external sequential multiplier.
// Optional WAIT watchdog with sticky timeout_err: define MULT_JOB_TIMEOUT_EN.
module mult_job_sequencer
  import mult_pkg::*;
#(
  parameter  int FIFO_DEPTH     = 4,
  parameter  int TIMEOUT_CYCLES = 15,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              timeout_err
);

  state_e              state_q;
  logic                mul_start_q;
  logic [OP_W-1:0]     mul_a_q;
  logic [OP_W-1:0]     mul_b_q;
  logic                out_valid_q;
  logic [PROD_W-1:0]   out_product_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [2*OP_W-1:0]   fifo_head;
  logic                timeout_hit;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  mult_op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * OP_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({in_a, in_b}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef MULT_JOB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_q;
  logic            timeout_err_q;

  // Fires on the last of TIMEOUT_CYCLES consecutive WAIT cycles without a completion.
  assign timeout_hit = (state_q == WAIT) && !mul_done &&
                       (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + TO_W'(1) : '0;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            {mul_a_q, mul_b_q} <= fifo_head;
            mul_start_q        <= 1'b1;
            state_q            <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // Completion pulses are only meaningful here; every other state drops them.
          if (mul_done) begin
            out_product_q <= mul_product;
            out_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end else if (timeout_hit) begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a 5-cycle multiplier model; honours MULT_JOB_TIMEOUT_EN.
module tb_mult_job_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_done;
  logic [7:0] mul_product;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_product;
  logic [2:0] fifo_level;
  logic       timeout_err;

  // Multiplier model outputs plus a directly injected completion pulse.
  logic       mdl_en   = 1'b1;
  logic       mdl_done = 1'b0;
  logic [7:0] mdl_prod = '0;
  logic       inj_done = 1'b0;
  logic [7:0] inj_prod = '0;
  int         mdl_cnt  = 0;
  logic [7:0] mdl_a    = '0;
  logic [7:0] mdl_b    = '0;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  assign mul_done    = mdl_done | inj_done;
  assign mul_product = inj_done ? inj_prod : mdl_prod;

  mult_job_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Done is seen by the DUT on the 5th rising edge after the one that samples mul_start.
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (rst) begin
      mdl_cnt = 0;
    end else begin
      if (mdl_cnt != 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) begin
          mdl_done = 1'b1;
          mdl_prod = mdl_a * mdl_b;
        end
      end
      if (mul_start && mdl_en) begin
        mdl_cnt = 5;
        mdl_a   = {4'd0, mul_a};
        mdl_b   = {4'd0, mul_b};
      end
    end
  end

  always @(posedge clk) begin
    if (mul_start) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the pair transfers on the next rising edge.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic       stable;
    int         s0;
    logic [7:0] exp_prod [5];

    exp_prod[0] = 8'd15;
    exp_prod[1] = 8'd16;
    exp_prod[2] = 8'd225;
    exp_prod[3] = 8'd0;
    exp_prod[4] = 8'd14;

    // Reset values while rst is held
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single job 3*5, result held with out_ready low
    push(4'd3, 4'd5);
    check("lat_level_after_push", fifo_level, 1);
    check("lat_no_start_yet", mul_start, 0);
    @(negedge clk);
    check("lat_start_high", mul_start, 1);
    check("lat_mul_a", mul_a, 3);
    check("lat_mul_b", mul_b, 5);
    check("lat_level_popped", fifo_level, 0);
    @(negedge clk);
    check("start_one_cycle", mul_start, 0);
    check("mul_a_held", mul_a, 3);
    wait_valid(20, seen);
    check("single_valid_seen", seen, 1);
    check("single_product", out_product, 15);
    check("single_start_count", start_cnt, 1);

    // Fill the queue while the first result is held
    push(4'd4, 4'd4);
    check("fill_level_1", fifo_level, 1);
    push(4'd15, 4'd15);
    check("fill_level_2", fifo_level, 2);
    push(4'd0, 4'd9);
    check("fill_level_3", fifo_level, 3);
    check("fill_ready_at_3", in_ready, 1);
    push(4'd7, 4'd2);
    check("fill_level_4", fifo_level, 4);
    check("full_in_ready_low", in_ready, 0);

    // Hold for 10 cycles: push attempt at full, stray done pulse
    s0       = start_cnt;
    stable   = 1'b1;
    in_valid = 1'b1;
    in_a     = 4'd1;
    in_b     = 4'd1;
    for (int i = 0; i < 10; i++) begin
      inj_done = (i == 4);
      inj_prod = 8'h77;
      @(negedge clk);
      if (out_product !== 8'd15 || out_valid !== 1'b1) stable = 1'b0;
    end
    inj_done = 1'b0;
    in_valid = 1'b0;
    check("hold_stable", stable, 1);
    check("hold_no_new_start", start_cnt, s0);
    check("hold_level_still_4", fifo_level, 4);

    // Release: results drain in input order
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(40, seen);
      check($sformatf("drain_seen_%0d", k), seen, 1);
      check($sformatf("drain_product_%0d", k), out_product, exp_prod[k]);
      @(negedge clk);
    end
    check("drain_level_empty", fifo_level, 0);
    check("drain_start_count", start_cnt, s0 + 4);

    // Reset during WAIT with two pairs queued, then a stale done
    push(4'd2, 4'd3);
    push(4'd5, 4'd5);
    push(4'd6, 4'd6);
    check("midjob_level_2", fifo_level, 2);
    rst = 1'b1;
    @(negedge clk);
    check("midjob_rst_level", fifo_level, 0);
    check("midjob_rst_in_ready", in_ready, 1);
    check("midjob_rst_mul_start", mul_start, 0);
    check("midjob_rst_mul_a", mul_a, 0);
    check("midjob_rst_mul_b", mul_b, 0);
    check("midjob_rst_out_valid", out_valid, 0);
    check("midjob_rst_out_product", out_product, 0);
    rst      = 1'b0;
    s0       = start_cnt;
    inj_done = 1'b1;
    inj_prod = 8'h5A;
    @(negedge clk);
    inj_done = 1'b0;
    stable   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) stable = 1'b0;
    end
    check("stale_done_ignored", stable, 1);
    check("stale_no_start", start_cnt, s0);
    check("stale_out_product", out_product, 0);

    // Multiplier never answers
    mdl_en = 1'b0;
    push(4'd9, 4'd9);
    push(4'd1, 4'd2);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mul_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("to_first_start", seen, 1);
    check("to_first_mul_a", mul_a, 9);
    repeat (15) @(negedge clk);
    check("to_err_before_limit", timeout_err, 0);
    @(negedge clk);
`ifdef MULT_JOB_TIMEOUT_EN
    check("to_err_set", timeout_err, 1);
    check("to_no_out_valid", out_valid, 0);
    @(negedge clk);
    check("to_next_start", mul_start, 1);
    check("to_next_mul_a", mul_a, 1);
    check("to_next_mul_b", mul_b, 2);
    check("to_level_empty", fifo_level, 0);
    repeat (5) @(negedge clk);
    check("to_err_sticky", timeout_err, 1);
`else
    check("nto_err_zero", timeout_err, 0);
    @(negedge clk);
    check("nto_no_next_start", mul_start, 0);
    check("nto_mul_a_held", mul_a, 9);
    check("nto_level_kept", fifo_level, 1);
    repeat (20) @(negedge clk);
    check("nto_err_still_zero", timeout_err, 0);
    check("nto_still_waiting", out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
